// File: rtl/axil_rou_cfg_slave_pkg.sv
// rtl/axil_rou_cfg_slave_pkg.sv - shared types, response codes and sizing helpers for the ROU/iROU table programmer
package rou_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_COMMIT,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;
    localparam logic [1:0]  DECERR    = 2'b11;
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // Number of ROU stage tables: one per power of two below MAX_LEN.
    function automatic int rou_stages(input int max_len);
        return $clog2(max_len);
    endfunction

    // Decoded byte-address width: 2*MAX_LEN entries of 8 bytes each.
    function automatic int rou_aw(input int max_len);
        return $clog2(max_len) + 4;
    endfunction

endpackage

// File: rtl/axil_rou_cfg_slave_if.sv
// rtl/axil_rou_cfg_slave_if.sv - AXI-Lite bundle for the BAR1 ROU configuration slave
interface axil_rou_cfg_slave_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_rou_cfg_slave_addr_decode.sv
// rtl/axil_rou_cfg_slave_addr_decode.sv - leading-one decode of a byte address into (irou, stage, entry, half)
module rou_addr_decode
    import rou_cfg_pkg::*;
#(
    parameter int MAX_LEN = 2048,
    parameter int STAGES  = rou_stages(MAX_LEN),
    parameter int AW      = rou_aw(MAX_LEN),
    parameter int STAGE_W = $clog2(STAGES) + 1
) (
    input  logic [31:0]        addr,
    output logic               irou,
    output logic [STAGE_W-1:0] stage,
    output logic [STAGES-1:0]  entry,
    output logic               half,
    output logic               rsvd,
    output logic               oor
);
    localparam int E_W = AW - 3;

    logic [E_W-1:0]     e;
    logic [E_W-1:0]     lead_mask;
    logic [E_W-1:0]     e_rem;
    logic [STAGE_W-1:0] q;
    logic               unused_addr;

    assign unused_addr = ^addr[1:0];

    // Find the leading one of the entry index; it selects the table and is stripped to give the entry.
    always_comb begin
        e         = addr[AW-1:3];
        q         = '0;
        lead_mask = '0;
        for (int i = 0; i < E_W; i++) begin
            if (e[i]) begin
                q         = STAGE_W'(i);
                lead_mask = E_W'(1) << i;
            end
        end
        e_rem = e & ~lead_mask;
        irou  = e[E_W-1];
        stage = irou ? '0 : q;
        entry = e_rem[STAGES-1:0];
        half  = addr[2];
        rsvd  = (e == '0);
        oor   = |addr[31:AW];
    end
endmodule

// File: rtl/axil_rou_cfg_slave.sv
// rtl/axil_rou_cfg_slave.sv - AXI-Lite ROU/iROU twiddle table programmer and readback; optional ROU_CFG_WR_CNT_EN write counter at 0x0
module axil_rou_cfg_slave
    import rou_cfg_pkg::*;
#(
    parameter int MAX_LEN    = 2048,
    parameter int LINE_SIZE  = 2,
    parameter int COEF_WIDTH = 54,
    parameter int RD_LAT     = 1,
    parameter int STAGES     = rou_stages(MAX_LEN),
    parameter int STAGE_W    = $clog2(STAGES) + 1,
    parameter int HALF       = COEF_WIDTH / 2
) (
    input  logic               clk,
    input  logic               rstn,
    axil_rou_cfg_slave_if.slave axil,
    output logic               tbl_we,
    output logic               tbl_re,
    output logic               tbl_irou,
    output logic [STAGE_W-1:0] tbl_stage,
    output logic [STAGES-1:0]  tbl_entry,
    output logic               tbl_half,
    output logic [HALF-1:0]    tbl_din,
    input  logic [HALF-1:0]    tbl_rdata
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    if (MAX_LEN < 4 || (MAX_LEN & (MAX_LEN - 1)) != 0 || LINE_SIZE < 1 ||
        (LINE_SIZE & (LINE_SIZE - 1)) != 0 || HALF > 31 || RD_LAT < 1) begin : g_bad_param
        $error("axil_rou_cfg_slave: unsupported parameter set");
    end

    state_t             state;
    logic [31:0]        aw_addr, ar_addr;
    logic [HALF-1:0]    w_data;
    logic [3:0]         w_strb;
    logic               aw_got, w_got, rd_pend;
    logic [CNT_W-1:0]   rd_cnt;
    logic               aw_hs, w_hs, ar_hs;
    logic [31:0]        dec_addr;
    logic               dec_irou, dec_half, dec_rsvd, dec_oor;
    logic [STAGE_W-1:0] dec_stage;
    logic [STAGES-1:0]  dec_entry;
    logic               cnt_hit, rd_err;
    logic [1:0]         wr_resp;
    logic               unused_wdata;

    assign unused_wdata = ^axil.s_wdata[31:HALF];
    assign aw_hs        = axil.s_awvalid & axil.s_awready;
    assign w_hs         = axil.s_wvalid & axil.s_wready;
    assign ar_hs        = axil.s_arvalid & axil.s_arready;
    assign dec_addr     = (state == RD_ISSUE) ? ar_addr : aw_addr;

    rou_addr_decode #(.MAX_LEN(MAX_LEN)) u_dec (
        .addr  (dec_addr),
        .irou  (dec_irou),
        .stage (dec_stage),
        .entry (dec_entry),
        .half  (dec_half),
        .rsvd  (dec_rsvd),
        .oor   (dec_oor)
    );

`ifdef ROU_CFG_WR_CNT_EN
    logic [31:0] wr_cnt;
    assign cnt_hit = dec_rsvd & ~dec_oor;

    // Count committed table writes; an accepted write to address 0 clears the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                              wr_cnt <= '0;
        else if (state == WR_COMMIT && cnt_hit && wr_resp == OKAY) wr_cnt <= '0;
        else if (tbl_we)                                        wr_cnt <= wr_cnt + 32'd1;
    end
`else
    assign cnt_hit = 1'b0;
`endif

    assign rd_err = dec_oor | (dec_rsvd & ~cnt_hit);

    // Write response: address errors take priority over a partial strobe.
    always_comb begin
        wr_resp = OKAY;
        if (dec_oor || (dec_rsvd && !cnt_hit)) wr_resp = DECERR;
        else if (w_strb != 4'hF)               wr_resp = SLVERR;
    end

    // Transaction FSM with registered readies, responses and table strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            axil.s_awready <= 1'b0;
            axil.s_wready  <= 1'b0;
            axil.s_arready <= 1'b0;
            axil.s_bvalid  <= 1'b0;
            axil.s_bresp   <= OKAY;
            axil.s_rvalid  <= 1'b0;
            axil.s_rresp   <= OKAY;
            axil.s_rdata   <= '0;
            tbl_we         <= 1'b0;
            tbl_re         <= 1'b0;
            tbl_irou       <= 1'b0;
            tbl_stage      <= '0;
            tbl_entry      <= '0;
            tbl_half       <= 1'b0;
            tbl_din        <= '0;
            aw_addr        <= '0;
            ar_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            rd_pend        <= 1'b0;
            rd_cnt         <= '0;
        end else begin
            tbl_we <= 1'b0;
            tbl_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin aw_addr <= axil.s_awaddr; aw_got <= 1'b1; end
                    if (w_hs)  begin w_data <= axil.s_wdata[HALF-1:0]; w_strb <= axil.s_wstrb; w_got <= 1'b1; end
                    if (ar_hs) begin ar_addr <= axil.s_araddr; rd_pend <= 1'b1; end
                    if (aw_hs || w_hs) begin
                        axil.s_awready <= ~aw_hs;
                        axil.s_wready  <= ~w_hs;
                        axil.s_arready <= 1'b0;
                        state          <= (aw_hs && w_hs) ? WR_COMMIT : WR_COLLECT;
                    end else if (ar_hs) begin
                        axil.s_awready <= 1'b0;
                        axil.s_wready  <= 1'b0;
                        axil.s_arready <= 1'b0;
                        state          <= RD_ISSUE;
                    end else begin
                        axil.s_awready <= 1'b1;
                        axil.s_wready  <= 1'b1;
                        axil.s_arready <= 1'b1;
                    end
                end
                WR_COLLECT: begin
                    if (aw_hs) begin aw_addr <= axil.s_awaddr; aw_got <= 1'b1; axil.s_awready <= 1'b0; end
                    if (w_hs)  begin w_data <= axil.s_wdata[HALF-1:0]; w_strb <= axil.s_wstrb; w_got <= 1'b1; axil.s_wready <= 1'b0; end
                    if ((aw_got || aw_hs) && (w_got || w_hs)) state <= WR_COMMIT;
                end
                WR_COMMIT: begin
                    tbl_irou     <= dec_irou;
                    tbl_stage    <= dec_stage;
                    tbl_entry    <= dec_entry;
                    tbl_half     <= dec_half;
                    tbl_din      <= w_data;
                    tbl_we       <= (wr_resp == OKAY) && !cnt_hit;
                    axil.s_bresp <= wr_resp;
                    aw_got       <= 1'b0;
                    w_got        <= 1'b0;
                    state        <= WR_RESP;
                end
                WR_RESP: begin
                    if (!axil.s_bvalid) begin
                        axil.s_bvalid <= 1'b1;
                    end else if (axil.s_bready) begin
                        axil.s_bvalid <= 1'b0;
                        state         <= rd_pend ? RD_ISSUE : IDLE;
                    end
                end
                RD_ISSUE: begin
                    rd_pend   <= 1'b0;
                    tbl_irou  <= dec_irou;
                    tbl_stage <= dec_stage;
                    tbl_entry <= dec_entry;
                    tbl_half  <= dec_half;
                    if (rd_err) begin
                        axil.s_rdata  <= DEAD_BEEF;
                        axil.s_rresp  <= DECERR;
                        axil.s_rvalid <= 1'b1;
                        state         <= RD_RESP;
`ifdef ROU_CFG_WR_CNT_EN
                    end else if (cnt_hit) begin
                        axil.s_rdata  <= wr_cnt;
                        axil.s_rresp  <= OKAY;
                        axil.s_rvalid <= 1'b1;
                        state         <= RD_RESP;
`endif
                    end else begin
                        tbl_re <= 1'b1;
                        rd_cnt <= '0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == CNT_W'(RD_LAT)) begin
                        axil.s_rdata  <= {{(32 - HALF){1'b0}}, tbl_rdata};
                        axil.s_rresp  <= OKAY;
                        axil.s_rvalid <= 1'b1;
                        state         <= RD_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                RD_RESP: begin
                    if (axil.s_rready) begin
                        axil.s_rvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_rou_cfg_slave.sv
// tb/tb_axil_rou_cfg_slave.sv - self-checking bench for axil_rou_cfg_slave with a behavioural table model
module tb_axil_rou_cfg_slave;
    import rou_cfg_pkg::*;

    localparam int MAX_LEN = 2048;
    localparam int RD_LAT  = 2;
    localparam int HALF    = 27;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tbl_we, tbl_re, tbl_irou, tbl_half;
    logic [4:0]  tbl_stage;
    logic [10:0] tbl_entry;
    logic [26:0] tbl_din, tbl_rdata;

    always #5 clk = ~clk;

    axil_rou_cfg_slave_if axil();

    axil_rou_cfg_slave #(.MAX_LEN(MAX_LEN), .LINE_SIZE(2), .COEF_WIDTH(54), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .axil      (axil),
        .tbl_we    (tbl_we),
        .tbl_re    (tbl_re),
        .tbl_irou  (tbl_irou),
        .tbl_stage (tbl_stage),
        .tbl_entry (tbl_entry),
        .tbl_half  (tbl_half),
        .tbl_din   (tbl_din),
        .tbl_rdata (tbl_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int b_hs_cyc = 0;

    typedef struct { logic irou; int stage; int entry; logic half; logic [26:0] din; int at; } tbl_op_t;
    tbl_op_t we_q[$];
    tbl_op_t re_q[$];

    logic [26:0] mem [int];
    logic [26:0] model [int];
    logic [26:0] pipe0 = '0, pipe1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tkey(input logic irou, input int stage, input int entry, input logic half);
        return (int'(irou) << 20) | (stage << 16) | (entry << 1) | int'(half);
    endfunction

    // Table stub: stores writes, returns read data RD_LAT cycles after tbl_re, garbage otherwise.
    always @(posedge clk) begin
        int k;
        k = tkey(tbl_irou, int'(tbl_stage), int'(tbl_entry), tbl_half);
        if (tbl_we) mem[k] = tbl_din;
        pipe0 <= tbl_re ? (mem.exists(k) ? mem[k] : 27'h0) : 27'h5A5A5A5;
        pipe1 <= pipe0;
    end
    assign tbl_rdata = pipe1;

    // Strobe monitor.
    always @(negedge clk) begin
        tbl_op_t t;
        t.irou = tbl_irou; t.stage = int'(tbl_stage); t.entry = int'(tbl_entry);
        t.half = tbl_half; t.din = tbl_din; t.at = cyc;
        if (tbl_we) we_q.push_back(t);
        if (tbl_re) re_q.push_back(t);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference address map from the arithmetic rules: e = addr/8, table = floor(log2(e)).
    function automatic void ref_decode(input logic [31:0] a, output logic err, output logic irou,
                                       output int stage, output int entry, output logic half);
        int e;
        e = int'(a >> 3);
        err = (a >= 32'h8000) || (e == 0);
        irou = 1'b0; stage = 0; entry = 0; half = a[2];
        if (!err) begin
            if (e >= MAX_LEN) begin
                irou = 1'b1; entry = e - MAX_LEN;
            end else begin
                while ((2 << stage) <= e) stage++;
                entry = e - (1 << stage);
            end
        end
    endfunction

    task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
        logic aw_done = 0, w_done = 0, err, irou, half;
        int k = 0, n = 0, stage, entry;
        logic [1:0] resp, exp_resp;
        we_q.delete();
        axil.s_awaddr = addr; axil.s_wdata = data; axil.s_wstrb = strb;
        while (!(aw_done && w_done) && k < 100) begin
            @(negedge clk);
            axil.s_awvalid = !aw_done && k >= aw_dly;
            axil.s_wvalid  = !w_done && k >= w_dly;
            if (axil.s_awvalid && axil.s_awready) aw_done = 1;
            if (axil.s_wvalid && axil.s_wready)   w_done = 1;
            k++;
        end
        check("wr_handshakes", {aw_done, w_done}, 2'b11);
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin axil.s_awvalid = 0; axil.s_wvalid = 0; end
        end while (!axil.s_bvalid && n < 50);
        check("b_latency", n, 3);
        repeat (b_dly) @(negedge clk);
        if (b_dly > 0) check("bvalid_hold", axil.s_bvalid, 1'b1);
        resp = axil.s_bresp;
        b_hs_cyc = cyc;
        axil.s_bready = 1;
        @(negedge clk);
        axil.s_bready = 0;
        check("bvalid_drop", axil.s_bvalid, 1'b0);
        ref_decode(addr, err, irou, stage, entry, half);
        exp_resp = err ? DECERR : (strb != 4'hF) ? SLVERR : OKAY;
        check("bresp", resp, exp_resp);
        check("we_count", we_q.size(), (exp_resp == OKAY) ? 1 : 0);
        if (exp_resp == OKAY && we_q.size() == 1) begin
            check("we_irou", we_q[0].irou, irou);
            check("we_half", we_q[0].half, half);
            check("we_entry", we_q[0].entry, entry);
            check("we_din", we_q[0].din, data[26:0]);
            if (!irou) check("we_stage", we_q[0].stage, stage);
            model[int'(addr >> 2)] = data[26:0];
        end
    endtask

    task automatic rd_txn(input logic [31:0] addr, input int r_dly, output int re_at);
        logic done = 0, err, irou, half;
        int k = 0, stage, entry;
        logic [31:0] data, exp_data;
        logic [1:0] resp;
        re_q.delete();
        re_at = -1;
        axil.s_araddr = addr;
        while (!done && k < 100) begin
            @(negedge clk);
            axil.s_arvalid = 1;
            if (axil.s_arready) done = 1;
            k++;
        end
        check("ar_handshake", done, 1'b1);
        @(negedge clk);
        axil.s_arvalid = 0;
        k = 0;
        while (!axil.s_rvalid && k < 200) begin @(negedge clk); k++; end
        check("rvalid_seen", axil.s_rvalid, 1'b1);
        repeat (r_dly) @(negedge clk);
        if (r_dly > 0) check("rvalid_hold", axil.s_rvalid, 1'b1);
        data = axil.s_rdata; resp = axil.s_rresp;
        axil.s_rready = 1;
        @(negedge clk);
        axil.s_rready = 0;
        check("rvalid_drop", axil.s_rvalid, 1'b0);
        ref_decode(addr, err, irou, stage, entry, half);
        check("rresp", resp, err ? DECERR : OKAY);
        check("re_count", re_q.size(), err ? 0 : 1);
        if (err) begin
            check("rdata_err", data, DEAD_BEEF);
        end else begin
            exp_data = model.exists(int'(addr >> 2)) ? {5'b0, model[int'(addr >> 2)]} : 32'h0;
            if (model.exists(int'(addr >> 2))) check("rdata", data, exp_data);
            if (re_q.size() == 1) begin
                re_at = re_q[0].at;
                check("re_irou", re_q[0].irou, irou);
                check("re_half", re_q[0].half, half);
                check("re_entry", re_q[0].entry, entry);
                if (!irou) check("re_stage", re_q[0].stage, stage);
            end
        end
    endtask

    initial begin
        int re_at, e, k;
        logic [31:0] a;
        logic [3:0] s;
        axil.s_awaddr = 0; axil.s_awvalid = 0; axil.s_wdata = 0; axil.s_wstrb = 0; axil.s_wvalid = 0;
        axil.s_bready = 0; axil.s_araddr = 0; axil.s_arvalid = 0; axil.s_rready = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", {axil.s_awready, axil.s_wready, axil.s_arready}, 3'b000);
        check("rst_valid", {axil.s_bvalid, axil.s_rvalid, tbl_we, tbl_re}, 4'b0000);
        check("rst_resp", {axil.s_bresp, axil.s_rresp}, 4'b0000);
        check("rst_rdata", axil.s_rdata, 32'h0);
        rstn = 1;

        wr_txn(32'h2008, 32'h0123_4567, 4'hF, 0, 2, 0);
        wr_txn(32'h4004, 32'h0ABC_DEF0, 4'hF, 2, 0, 0);
        wr_txn(32'h0018, 32'h0000_0010, 4'hF, 0, 0, 0);
        rd_txn(32'h0018, 0, re_at);

        wr_txn(32'h8000, 32'h1111_1111, 4'hF, 0, 0, 0);
        wr_txn(32'h2008, 32'h2222_2222, 4'h3, 1, 0, 0);
        rd_txn(32'h0000, 0, re_at);
        rd_txn(32'h8000, 1, re_at);

        fork
            wr_txn(32'h2010, 32'h0765_4321, 4'hF, 0, 0, 5);
            rd_txn(32'h2010, 5, re_at);
        join
        check("rd_after_b", re_at > b_hs_cyc, 1'b1);

        axil.s_awaddr = 32'h2008;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            axil.s_awvalid = 1;
            k++;
            if (axil.s_awready) break;
        end
        @(negedge clk);
        axil.s_awvalid = 0;
        @(negedge clk);
        check("collect_wready", axil.s_wready, 1'b1);
        we_q.delete();
        rstn = 0;
        #1;
        check("midrst_ready", {axil.s_awready, axil.s_wready, axil.s_arready}, 3'b000);
        check("midrst_valid", {axil.s_bvalid, axil.s_rvalid, tbl_we, tbl_re}, 4'b0000);
        repeat (2) @(negedge clk);
        check("midrst_no_we", we_q.size(), 0);
        rstn = 1;
        wr_txn(32'h2008, 32'h0333_3333, 4'hF, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            e = $urandom_range(1, 2 * MAX_LEN - 1);
            a = 32'(e) * 8 + 32'($urandom_range(0, 1)) * 4;
            if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(15, 31));
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            wr_txn(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        foreach (model[w]) rd_txn(32'(w) * 4, $urandom_range(0, 2), re_at);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
